// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: the 32-bit word and the RAM handshake state seen by
// memory_control, plus the default RAM endpoint configuration.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    localparam int RAM_DEFAULT_LAT   = 2;
    localparam int RAM_DEFAULT_DEPTH = 256;

    // Number of word-index bits for a RAM of the given depth.
    function automatic int ram_idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/ram_responder_if.sv
// RAM-side request interface between memory_control (master) and the RAM
// endpoint (slave).
interface ram_responder_if;
    import cpu_types_pkg::*;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport master (
        output ramREN, ramWEN, ramaddr, ramstore,
        input  ramload, ramstate
    );

    modport slave (
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramload, ramstate
    );

endinterface

// File: rtl/ram_word_array.sv
// DEPTH x 32-bit word storage: one synchronous write port, combinational read
// at the same index, every word cleared by the asynchronous reset.
module ram_word_array
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = RAM_DEFAULT_DEPTH,
    localparam int IDX_W = ram_idx_w(DEPTH)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_idx,
    input  word_t            i_wdata,
    output word_t            o_rdata
);

    word_t r_mem [DEPTH];

    // Storage: clear everything on reset, otherwise write one word when enabled.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/ram_responder.sv
// Behavioural RAM endpoint answering memory_control's RAM-side requests with a
// programmable access latency (LAT wait cycles in BUSY, then one ACCESS cycle).
// Optional build macro RAM_ALIGN_CHECK_EN: when defined, a request with a
// misaligned byte address (ramaddr[1:0] != 0) is reported as ERROR; when
// undefined the low address bits are ignored and the aligned word is used.
module ram_responder
    import cpu_types_pkg::*;
#(
    parameter int LAT   = RAM_DEFAULT_LAT,
    parameter int DEPTH = RAM_DEFAULT_DEPTH
) (
    input  logic           CLK,
    input  logic           nRST,
    ram_responder_if.slave bus
);

    localparam int IDX_W = ram_idx_w(DEPTH);
    // cnt only ever holds LAT-1 down to 0
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LAT > 0) ? LAT - 1 : 0);

    ramstate_t        r_state;
    ramstate_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_ren;
    logic             r_wen;
    word_t            r_addr;
    word_t            r_load;
    word_t            w_rdata;
    logic [IDX_W-1:0] w_idx;
    logic             w_upper_bad;
    logic             w_misalign;
    logic             w_bad;
    logic             w_idle;
    logic             w_new;
    logic             w_latch;
    logic             w_do_access;

    assign w_idx       = bus.ramaddr[IDX_W+1:2];
    assign w_upper_bad = (bus.ramaddr >> (IDX_W + 2)) != '0;

`ifdef RAM_ALIGN_CHECK_EN
    assign w_misalign  = (bus.ramREN | bus.ramWEN) & (bus.ramaddr[1:0] != 2'b00);
`else
    assign w_misalign  = 1'b0;
`endif

    assign w_bad  = (bus.ramREN & bus.ramWEN) | w_upper_bad | w_misalign;
    assign w_idle = ~bus.ramREN & ~bus.ramWEN;
    // Only a BUSY wait on the identical request continues counting; anything
    // else starts the full latency again.
    assign w_new  = (r_state != BUSY) || (bus.ramREN != r_ren) ||
                    (bus.ramWEN != r_wen) || (bus.ramaddr != r_addr);

    // Next state, count and access strobe, evaluated in rule priority order.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_do_access = 1'b0;
        if (w_bad) begin
            w_state_nxt = ERROR;
        end else if (w_idle) begin
            w_state_nxt = FREE;
            w_cnt_nxt   = '0;
        end else if (w_new) begin
            w_latch = 1'b1;
            if (LAT == 0) begin
                w_state_nxt = ACCESS;
                w_do_access = 1'b1;
            end else begin
                w_state_nxt = BUSY;
                w_cnt_nxt   = CNT_INIT;
            end
        end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
            w_state_nxt = ACCESS;
            w_do_access = 1'b1;
        end
    end

    // State, latency counter and latched request registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= FREE;
            r_cnt   <= '0;
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_ren  <= bus.ramREN;
                r_wen  <= bus.ramWEN;
                r_addr <= bus.ramaddr;
            end
        end
    end

    // Read data register: updated only on the edge that completes an access;
    // a write echoes the stored data.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_load <= '0;
        end else if (w_do_access) begin
            r_load <= bus.ramWEN ? bus.ramstore : w_rdata;
        end
    end

    ram_word_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .CLK     (CLK),
        .nRST    (nRST),
        .i_we    (w_do_access & bus.ramWEN),
        .i_idx   (w_idx),
        .i_wdata (bus.ramstore),
        .o_rdata (w_rdata)
    );

    assign bus.ramstate = r_state;
    assign bus.ramload  = r_load;

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: one instance with LAT=2 and one with LAT=0, both
// DEPTH=256, checked cycle by cycle against a run-length reference model.
module tb_ram_responder;
    import cpu_types_pkg::*;

    localparam int DEPTH = 256;
    localparam int IDXW  = 8;

    logic clk;
    logic nrst;
    int   n_tests;
    int   n_fail;

    ram_responder_if ifa ();
    ram_responder_if ifb ();

    ram_responder #(.LAT(2), .DEPTH(DEPTH)) dut_a (.CLK(clk), .nRST(nrst), .bus(ifa));
    ram_responder #(.LAT(0), .DEPTH(DEPTH)) dut_b (.CLK(clk), .nRST(nrst), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a request completes once it has been presented on
    // LAT+1 consecutive edges as one uninterrupted attempt.
    word_t     mem_m [2][DEPTH];
    int        m_run [2];
    logic      m_ren [2];
    logic      m_wen [2];
    word_t     m_addr [2];
    word_t     m_load [2];
    ramstate_t m_state [2];

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++) mem_m[d][i] = '0;
            m_run[d]   = 0;
            m_ren[d]   = 1'b0;
            m_wen[d]   = 1'b0;
            m_addr[d]  = '0;
            m_load[d]  = '0;
            m_state[d] = FREE;
        end
    endtask

    task automatic model_edge(input int d, input logic ren, input logic wen,
                              input word_t addr, input word_t store);
        logic bad;
        int   idx;
        bad = (ren && wen) || ((addr >> (IDXW + 2)) != 0);
`ifdef RAM_ALIGN_CHECK_EN
        if ((ren || wen) && (addr[1:0] != 2'b00)) bad = 1'b1;
`endif
        idx = int'(addr[IDXW+1:2]);
        if (bad) begin
            m_state[d] = ERROR;
            m_run[d]   = 0;
        end else if (!ren && !wen) begin
            m_state[d] = FREE;
            m_run[d]   = 0;
        end else begin
            if (m_run[d] > 0 && ren == m_ren[d] && wen == m_wen[d] && addr == m_addr[d])
                m_run[d] = m_run[d] + 1;
            else
                m_run[d] = 1;
            m_ren[d]  = ren;
            m_wen[d]  = wen;
            m_addr[d] = addr;
            if (m_run[d] == lat_of(d) + 1) begin
                m_state[d] = ACCESS;
                m_run[d]   = 0;
                if (wen) begin
                    mem_m[d][idx] = store;
                    m_load[d]     = store;
                end else begin
                    m_load[d] = mem_m[d][idx];
                end
            end else begin
                m_state[d] = BUSY;
            end
        end
    endtask

    // Present one request to DUT d for one edge (the other DUT idles), advance
    // both models, and return 1 ns after the edge.
    task automatic step(input int d, input logic ren, input logic wen,
                        input word_t addr, input word_t store);
        if (d == 0) begin
            ifa.ramREN = ren; ifa.ramWEN = wen; ifa.ramaddr = addr; ifa.ramstore = store;
            ifb.ramREN = 1'b0; ifb.ramWEN = 1'b0; ifb.ramaddr = '0; ifb.ramstore = '0;
        end else begin
            ifb.ramREN = ren; ifb.ramWEN = wen; ifb.ramaddr = addr; ifb.ramstore = store;
            ifa.ramREN = 1'b0; ifa.ramWEN = 1'b0; ifa.ramaddr = '0; ifa.ramstore = '0;
        end
        @(posedge clk);
        if (d == 0) begin
            model_edge(0, ren, wen, addr, store);
            model_edge(1, 1'b0, 1'b0, '0, '0);
        end else begin
            model_edge(1, ren, wen, addr, store);
            model_edge(0, 1'b0, 1'b0, '0, '0);
        end
        #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        ifa.ramREN = 1'b0; ifa.ramWEN = 1'b0; ifa.ramaddr = '0; ifa.ramstore = '0;
        ifb.ramREN = 1'b0; ifb.ramWEN = 1'b0; ifb.ramaddr = '0; ifb.ramstore = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;
        n_tests++; if (ifa.ramstate !== FREE) begin n_fail++; $display("FAIL reset_state_a: got %s want FREE", ifa.ramstate.name()); end
        n_tests++; if (ifa.ramload !== 32'h0) begin n_fail++; $display("FAIL reset_load_a: got %h want 0", ifa.ramload); end
        n_tests++; if (ifb.ramstate !== FREE) begin n_fail++; $display("FAIL reset_state_b: got %s want FREE", ifb.ramstate.name()); end
        n_tests++; if (ifb.ramload !== 32'h0) begin n_fail++; $display("FAIL reset_load_b: got %h want 0", ifb.ramload); end
    endtask

    task automatic test_read_latency();
        ramstate_t seq [3];
        seq = '{BUSY, BUSY, ACCESS};
        step(0, 1'b0, 1'b0, '0, '0);
        n_tests++; if (ifa.ramstate !== FREE) begin n_fail++; $display("FAIL lat_idle: got %s want FREE", ifa.ramstate.name()); end
        for (int i = 0; i < 3; i++) begin
            step(0, 1'b1, 1'b0, 32'h10, $urandom);
            n_tests++;
            if (ifa.ramstate !== seq[i]) begin n_fail++; $display("FAIL lat_seq%0d: got %s want %s", i, ifa.ramstate.name(), seq[i].name()); end
        end
        n_tests++; if (ifa.ramload !== 32'h0) begin n_fail++; $display("FAIL lat_load: got %h want 0", ifa.ramload); end
        step(0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_write_read();
        bit done;
        done = 0;
        for (int i = 0; i < 8 && !done; i++) begin
            step(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
            n_tests++; if (ifa.ramstate !== m_state[0]) begin n_fail++; $display("FAIL wr_state: got %s want %s", ifa.ramstate.name(), m_state[0].name()); end
            if (ifa.ramstate == ACCESS) begin
                done = 1;
                n_tests++; if (ifa.ramload !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_echo: got %h want deadbeef", ifa.ramload); end
            end
        end
        if (!done) begin n_tests++; n_fail++; $display("FAIL wr_timeout: got no ACCESS want ACCESS"); end
        step(0, 1'b0, 1'b0, '0, '0);
        done = 0;
        for (int i = 0; i < 8 && !done; i++) begin
            step(0, 1'b1, 1'b0, 32'h10, $urandom);
            n_tests++; if (ifa.ramstate !== m_state[0]) begin n_fail++; $display("FAIL rd_state: got %s want %s", ifa.ramstate.name(), m_state[0].name()); end
            if (ifa.ramstate == ACCESS) begin
                done = 1;
                n_tests++; if (ifa.ramload !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", ifa.ramload); end
            end
        end
        if (!done) begin n_tests++; n_fail++; $display("FAIL rd_timeout: got no ACCESS want ACCESS"); end
        step(0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_abort();
        ramstate_t seq [3];
        seq = '{BUSY, BUSY, ACCESS};
        step(0, 1'b1, 1'b0, 32'h20, '0);
        n_tests++; if (ifa.ramstate !== BUSY) begin n_fail++; $display("FAIL abort_first: got %s want BUSY", ifa.ramstate.name()); end
        for (int i = 0; i < 3; i++) begin
            step(0, 1'b1, 1'b0, 32'h24, '0);
            n_tests++;
            if (ifa.ramstate !== seq[i]) begin n_fail++; $display("FAIL abort_seq%0d: got %s want %s", i, ifa.ramstate.name(), seq[i].name()); end
        end
        n_tests++; if (ifa.ramload !== m_load[0]) begin n_fail++; $display("FAIL abort_load: got %h want %h", ifa.ramload, m_load[0]); end
        step(0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_error();
        bit done;
        for (int i = 0; i < 2; i++) begin
            step(0, 1'b1, 1'b1, 32'h10, 32'h11111111);
            n_tests++; if (ifa.ramstate !== ERROR) begin n_fail++; $display("FAIL err_both%0d: got %s want ERROR", i, ifa.ramstate.name()); end
        end
        done = 0;
        for (int i = 0; i < 8 && !done; i++) begin
            step(0, 1'b1, 1'b0, 32'h10, '0);
            n_tests++; if (ifa.ramstate !== m_state[0]) begin n_fail++; $display("FAIL err_rd_state: got %s want %s", ifa.ramstate.name(), m_state[0].name()); end
            if (ifa.ramstate == ACCESS) begin
                done = 1;
                n_tests++; if (ifa.ramload !== 32'hDEADBEEF) begin n_fail++; $display("FAIL err_mem_kept: got %h want deadbeef", ifa.ramload); end
            end
        end
        if (!done) begin n_tests++; n_fail++; $display("FAIL err_rd_timeout: got no ACCESS want ACCESS"); end
        step(0, 1'b0, 1'b0, '0, '0);
        step(0, 1'b1, 1'b0, 32'h400, '0);
        n_tests++; if (ifa.ramstate !== ERROR) begin n_fail++; $display("FAIL err_range: got %s want ERROR", ifa.ramstate.name()); end
`ifdef RAM_ALIGN_CHECK_EN
        step(0, 1'b1, 1'b0, 32'h12, '0);
        n_tests++; if (ifa.ramstate !== ERROR) begin n_fail++; $display("FAIL err_align: got %s want ERROR", ifa.ramstate.name()); end
`else
        done = 0;
        for (int i = 0; i < 8 && !done; i++) begin
            step(0, 1'b1, 1'b0, 32'h12, '0);
            n_tests++; if (ifa.ramstate !== m_state[0]) begin n_fail++; $display("FAIL unalign_state: got %s want %s", ifa.ramstate.name(), m_state[0].name()); end
            if (ifa.ramstate == ACCESS) begin
                done = 1;
                n_tests++; if (ifa.ramload !== 32'hDEADBEEF) begin n_fail++; $display("FAIL unalign_data: got %h want deadbeef", ifa.ramload); end
            end
        end
        if (!done) begin n_tests++; n_fail++; $display("FAIL unalign_timeout: got no ACCESS want ACCESS"); end
`endif
        step(0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_lat0();
        step(1, 1'b1, 1'b0, 32'h10, '0);
        n_tests++; if (ifb.ramstate !== ACCESS) begin n_fail++; $display("FAIL lat0_rd_state: got %s want ACCESS", ifb.ramstate.name()); end
        n_tests++; if (ifb.ramload !== 32'h0) begin n_fail++; $display("FAIL lat0_rd_data: got %h want 0", ifb.ramload); end
        for (int i = 0; i < 2; i++) begin
            step(1, 1'b0, 1'b1, 32'h10, 32'h12345678);
            n_tests++; if (ifb.ramstate !== ACCESS) begin n_fail++; $display("FAIL lat0_wr_state%0d: got %s want ACCESS", i, ifb.ramstate.name()); end
            n_tests++; if (ifb.ramload !== 32'h12345678) begin n_fail++; $display("FAIL lat0_wr_echo%0d: got %h want 12345678", i, ifb.ramload); end
        end
        step(1, 1'b1, 1'b0, 32'h10, '0);
        n_tests++; if (ifb.ramload !== 32'h12345678) begin n_fail++; $display("FAIL lat0_rb: got %h want 12345678", ifb.ramload); end
        step(1, 1'b0, 1'b0, '0, '0);
        n_tests++; if (ifb.ramstate !== FREE) begin n_fail++; $display("FAIL lat0_free: got %s want FREE", ifb.ramstate.name()); end
    endtask

    task automatic test_random();
        logic  ren, wen;
        word_t addr;
        int    kind;
        ren = 1'b0; wen = 1'b0; addr = '0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                kind = $urandom_range(0, 11);
                addr = word_t'($urandom_range(0, 7)) << 2;
                ren  = 1'b0;
                wen  = 1'b0;
                if (kind >= 2 && kind <= 5) ren = 1'b1;
                else if (kind >= 6 && kind <= 8) wen = 1'b1;
                else if (kind == 9) begin ren = 1'b1; wen = 1'b1; end
                else if (kind == 10) begin ren = 1'b1; addr = addr | 32'h400; end
                else if (kind == 11) begin wen = 1'b1; addr = addr | word_t'($urandom_range(1, 3)); end
            end
            step(0, ren, wen, addr, $urandom);
            n_tests++; if (ifa.ramstate !== m_state[0]) begin n_fail++; $display("FAIL rand_state c%0d: got %s want %s", c, ifa.ramstate.name(), m_state[0].name()); end
            n_tests++; if (ifa.ramload !== m_load[0]) begin n_fail++; $display("FAIL rand_load c%0d: got %h want %h", c, ifa.ramload, m_load[0]); end
        end
        step(0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_reset_mid();
        bit done;
        step(0, 1'b0, 1'b1, 32'h10, 32'hCAFEF00D);
        n_tests++; if (ifa.ramstate !== BUSY) begin n_fail++; $display("FAIL rstmid_busy: got %s want BUSY", ifa.ramstate.name()); end
        nrst = 1'b0;
        #2;
        n_tests++; if (ifa.ramstate !== FREE) begin n_fail++; $display("FAIL rstmid_state: got %s want FREE", ifa.ramstate.name()); end
        n_tests++; if (ifa.ramload !== 32'h0) begin n_fail++; $display("FAIL rstmid_load: got %h want 0", ifa.ramload); end
        model_reset();
        ifa.ramREN = 1'b0; ifa.ramWEN = 1'b0;
        #1 nrst = 1'b1;
        done = 0;
        for (int i = 0; i < 8 && !done; i++) begin
            step(0, 1'b1, 1'b0, 32'h10, '0);
            n_tests++; if (ifa.ramstate !== m_state[0]) begin n_fail++; $display("FAIL rstmid_rd_state: got %s want %s", ifa.ramstate.name(), m_state[0].name()); end
            if (ifa.ramstate == ACCESS) begin
                done = 1;
                n_tests++; if (ifa.ramload !== 32'h0) begin n_fail++; $display("FAIL rstmid_cleared: got %h want 0", ifa.ramload); end
            end
        end
        if (!done) begin n_tests++; n_fail++; $display("FAIL rstmid_timeout: got no ACCESS want ACCESS"); end
        step(0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_read_latency();
        test_write_read();
        test_abort();
        test_error();
        test_lat0();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
